pcie_tlp_fifo: RTL and testbench

Synchronous single-clock FIFO for segmented TLP streams, one instance per demultiplexer output port.
- Absorbs backpressure from slow consumers (register-file BAR handlers, DMA completion paths) so one stalled port does not hold the shared TLP input for long.
- Passes all TLP sideband fields through unchanged.
- Publishes occupancy and watermark status for upstream flow control.

---
 rtl/pcie_tlp_fifo.sv | 143 ++++++++++++++
 tb/tb_pcie_tlp_fifo.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_tlp_fifo.sv
// pcie_tlp_fifo
//   Single-clock FIFO for one demultiplexer output port of a segmented TLP
//   stream. Absorbs backpressure from a slow consumer, carries every sideband
//   field through unchanged, and publishes occupancy, a watermark flag and a
//   sticky framing-error flag for upstream flow control.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_tlp_*              input beat: data, strb, hdr, bar_id, func_num, error,
//                         valid, sop, eop; in_tlp_ready = a beat can be taken
//   out_tlp_*             registered output beat with the same fields;
//                         out_tlp_ready = consumer takes the beat
//   status_count          entries in memory (output register not counted)
//   status_watermark      status_count >= WATERMARK
//   status_frame_err      sticky sop/eop sequencing error seen on the input
module pcie_tlp_fifo #(
  parameter int DEPTH              = 16,
  parameter int TLP_SEG_COUNT      = 1,
  parameter int TLP_SEG_DATA_WIDTH = 256,
  parameter int TLP_SEG_STRB_WIDTH = TLP_SEG_DATA_WIDTH/32,
  parameter int TLP_SEG_HDR_WIDTH  = 128,
  parameter int WATERMARK          = DEPTH/2
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [TLP_SEG_COUNT*TLP_SEG_DATA_WIDTH-1:0]  in_tlp_data,
  input  logic [TLP_SEG_COUNT*TLP_SEG_STRB_WIDTH-1:0]  in_tlp_strb,
  input  logic [TLP_SEG_COUNT*TLP_SEG_HDR_WIDTH-1:0]   in_tlp_hdr,
  input  logic [TLP_SEG_COUNT*3-1:0]                   in_tlp_bar_id,
  input  logic [TLP_SEG_COUNT*8-1:0]                   in_tlp_func_num,
  input  logic [TLP_SEG_COUNT*4-1:0]                   in_tlp_error,
  input  logic [TLP_SEG_COUNT-1:0]                     in_tlp_valid,
  input  logic [TLP_SEG_COUNT-1:0]                     in_tlp_sop,
  input  logic [TLP_SEG_COUNT-1:0]                     in_tlp_eop,
  output logic                                         in_tlp_ready,
  output logic [TLP_SEG_COUNT*TLP_SEG_DATA_WIDTH-1:0]  out_tlp_data,
  output logic [TLP_SEG_COUNT*TLP_SEG_STRB_WIDTH-1:0]  out_tlp_strb,
  output logic [TLP_SEG_COUNT*TLP_SEG_HDR_WIDTH-1:0]   out_tlp_hdr,
  output logic [TLP_SEG_COUNT*3-1:0]                   out_tlp_bar_id,
  output logic [TLP_SEG_COUNT*8-1:0]                   out_tlp_func_num,
  output logic [TLP_SEG_COUNT*4-1:0]                   out_tlp_error,
  output logic [TLP_SEG_COUNT-1:0]                     out_tlp_valid,
  output logic [TLP_SEG_COUNT-1:0]                     out_tlp_sop,
  output logic [TLP_SEG_COUNT-1:0]                     out_tlp_eop,
  input  logic                                         out_tlp_ready,
  output logic [$clog2(DEPTH):0]                       status_count,
  output logic                                         status_watermark,
  output logic                                         status_frame_err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int DW  = TLP_SEG_COUNT*TLP_SEG_DATA_WIDTH;
  localparam int SW  = TLP_SEG_COUNT*TLP_SEG_STRB_WIDTH;
  localparam int HW  = TLP_SEG_COUNT*TLP_SEG_HDR_WIDTH;
  localparam int EW  = DW + SW + HW + TLP_SEG_COUNT*(3 + 8 + 4 + 2);
  localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] WM_LEVEL = (AW+1)'(WATERMARK);

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry_reg;

  logic [AW:0] wr_ptr_reg, wr_ptr_next;
  logic [AW:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0] count_reg, count_next;
  logic        empty, full_next;
  logic        wr_en, rd_en;
  logic        in_ready_reg;
  logic        out_valid_reg;
  logic        watermark_reg;
  logic        in_frame_reg;
  logic        frame_err_reg;

  assign wr_entry = {in_tlp_data, in_tlp_strb, in_tlp_hdr, in_tlp_bar_id,
                     in_tlp_func_num, in_tlp_error, in_tlp_sop, in_tlp_eop};

  assign empty = (wr_ptr_reg == rd_ptr_reg);

  // in_ready_reg mirrors !full of the registered pointers; the rst term only
  // forces ready low during a reset cycle that follows normal operation.
  assign in_tlp_ready = in_ready_reg && !rst;

  assign wr_en = in_tlp_valid[0] && in_tlp_ready;
  // The output register doubles as the registered memory read stage: it
  // refills whenever it is empty or its beat is being taken this cycle.
  assign rd_en = !empty && (!out_valid_reg || out_tlp_ready);

  assign wr_ptr_next = wr_ptr_reg + (AW+1)'(wr_en);
  assign rd_ptr_next = rd_ptr_reg + (AW+1)'(rd_en);
  assign count_next  = wr_ptr_next - rd_ptr_next;
  assign full_next   = ((wr_ptr_next ^ rd_ptr_next) == FULL_XOR);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      watermark_reg <= 1'b0;
      in_frame_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      in_ready_reg  <= !full_next;
      watermark_reg <= (count_next >= WM_LEVEL);
      if (rd_en) begin
        out_valid_reg <= 1'b1;
      end else if (out_tlp_ready) begin
        out_valid_reg <= 1'b0;
      end
      if (wr_en) begin
        // sop must be 1 exactly when no frame is open; equality covers both
        // the "sop inside a frame" and "continuation outside a frame" cases.
        if (in_tlp_sop[0] == in_frame_reg) begin
          frame_err_reg <= 1'b1;
        end
        in_frame_reg <= !in_tlp_eop[0];
      end
    end
  end

  // Storage and output fields carry no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_entry;
    end
    if (rd_en) begin
      rd_entry_reg <= mem[rd_ptr_reg[AW-1:0]];
    end
  end

  assign {out_tlp_data, out_tlp_strb, out_tlp_hdr, out_tlp_bar_id,
          out_tlp_func_num, out_tlp_error, out_tlp_sop, out_tlp_eop} = rd_entry_reg;

  assign out_tlp_valid    = {TLP_SEG_COUNT{out_valid_reg}};
  assign status_count     = count_reg;
  assign status_watermark = watermark_reg;
  assign status_frame_err = frame_err_reg;

endmodule

// File: tb/tb_pcie_tlp_fifo.sv
// tb_pcie_tlp_fifo
//   Self-checking bench for pcie_tlp_fifo: a per-cycle vector table for reset,
//   latency and framing, hand-written fill / wrap / mid-packet-reset sequences,
//   and random valid/ready traffic, all tracked by a queue-based reference.
module tb_pcie_tlp_fifo;

  localparam int DEPTH = 16;
  localparam int WM    = DEPTH/2;

  typedef struct packed {
    logic [255:0] data;
    logic [7:0]   strb;
    logic [127:0] hdr;
    logic [2:0]   bar;
    logic [7:0]   func;
    logic [3:0]   err;
    logic         sop;
    logic         eop;
  } beat_t;

  typedef struct {
    bit rst, iv, sop, eop, ordy;
    int e_rdy, e_ov, e_cnt, e_wm, e_err;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst  = 1'b1;
  logic  iv   = 1'b0;
  logic  ordy = 1'b0;
  beat_t in_b = '0;
  beat_t out_b;

  logic         in_tlp_ready;
  logic [255:0] out_tlp_data;
  logic [7:0]   out_tlp_strb;
  logic [127:0] out_tlp_hdr;
  logic [2:0]   out_tlp_bar_id;
  logic [7:0]   out_tlp_func_num;
  logic [3:0]   out_tlp_error;
  logic [0:0]   out_tlp_valid, out_tlp_sop, out_tlp_eop;
  logic [4:0]   status_count;
  logic         status_watermark, status_frame_err;

  pcie_tlp_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_tlp_data(in_b.data), .in_tlp_strb(in_b.strb), .in_tlp_hdr(in_b.hdr),
    .in_tlp_bar_id(in_b.bar), .in_tlp_func_num(in_b.func), .in_tlp_error(in_b.err),
    .in_tlp_valid(iv), .in_tlp_sop(in_b.sop), .in_tlp_eop(in_b.eop),
    .in_tlp_ready(in_tlp_ready),
    .out_tlp_data(out_tlp_data), .out_tlp_strb(out_tlp_strb), .out_tlp_hdr(out_tlp_hdr),
    .out_tlp_bar_id(out_tlp_bar_id), .out_tlp_func_num(out_tlp_func_num),
    .out_tlp_error(out_tlp_error), .out_tlp_valid(out_tlp_valid),
    .out_tlp_sop(out_tlp_sop), .out_tlp_eop(out_tlp_eop), .out_tlp_ready(ordy),
    .status_count(status_count), .status_watermark(status_watermark),
    .status_frame_err(status_frame_err)
  );

  assign out_b = {out_tlp_data, out_tlp_strb, out_tlp_hdr, out_tlp_bar_id,
                  out_tlp_func_num, out_tlp_error, out_tlp_sop, out_tlp_eop};

  int errors = 0;
  int checks = 0;

  // Reference: beats held in memory (queue), the output slot, ready, framing.
  beat_t mq[$];
  bit    m_ov = 0;
  beat_t m_ob = '0;
  bit    m_rdy = 0;
  bit    m_err = 0;
  bit    m_inframe = 0;
  int    n_acc = 0;
  int    n_cons = 0;
  bit    last_acc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_beat(input string name, input beat_t act, input beat_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got data=%h hdr=%h sop=%b eop=%b expected data=%h hdr=%h sop=%b eop=%b",
               name, act.data, act.hdr, act.sop, act.eop, exp.data, exp.hdr, exp.sop, exp.eop);
    end
  endtask

  function automatic beat_t mk_beat(input int seq, input bit sop, input bit eop, input bit rnd);
    beat_t b;
    b.data = {32{8'hA5}};
    if (rnd) begin
      for (int w = 0; w < 8; w++) b.data[w*32 +: 32] = $urandom();
    end
    b.data[31:0] = b.data[31:0] ^ 32'(seq);
    b.strb = 8'(seq * 3 + 1);
    b.hdr  = {32'h4A000001, 32'(seq), 32'hCAFE0000, 32'(seq ^ 32'h55)};
    b.bar  = 3'(seq);
    b.func = 8'(seq + 7);
    b.err  = 4'(seq >> 2);
    b.sop  = sop;
    b.eop  = eop;
    return b;
  endfunction

  // One clock: predict the edge from current inputs, then compare DUT vs model.
  task automatic do_cycle(output bit acc);
    bit    cons, hold;
    beat_t pre;
    acc  = iv && m_rdy && !rst;
    cons = m_ov && ordy && !rst;
    hold = (out_tlp_valid === 1'b1) && !ordy && !rst;
    pre  = out_b;
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      m_ov = 0; m_rdy = 0; m_err = 0; m_inframe = 0;
    end else begin
      if (cons) n_cons++;
      if (mq.size() > 0 && (!m_ov || ordy)) begin
        m_ob = mq.pop_front();
        m_ov = 1;
      end else if (ordy) begin
        m_ov = 0;
      end
      if (acc) begin
        if (in_b.sop == m_inframe) m_err = 1;
        m_inframe = !in_b.eop;
        mq.push_back(in_b);
        n_acc++;
      end
      m_rdy = (mq.size() < DEPTH);
    end
    chk("in_ready", int'(in_tlp_ready), int'(m_rdy && !rst));
    chk("out_valid", int'(out_tlp_valid), int'(m_ov));
    if (m_ov) chk_beat("out_beat", out_b, m_ob);
    chk("status_count", int'(status_count), mq.size());
    chk("watermark", int'(status_watermark), int'(mq.size() >= WM));
    chk("frame_err", int'(status_frame_err), int'(m_err));
    if (hold && !rst) chk_beat("hold_stable", out_b, pre);
  endtask

  task automatic reset_dut();
    rst = 1; iv = 0;
    do_cycle(last_acc);
    do_cycle(last_acc);
    rst = 0;
    do_cycle(last_acc);
  endtask

  vec_t vtab[17];
  int   seq;
  int   a0, c0, budget;

  initial begin
    // rst iv sop eop ordy | rdy ov cnt wm err  (state after the row's edge)
    vtab[0]  = '{1,0,0,0,1, 0,0,0,0,0};
    vtab[1]  = '{1,0,0,0,1, 0,0,0,0,0};
    vtab[2]  = '{0,0,0,0,1, 1,0,0,0,0};
    vtab[3]  = '{0,1,1,1,1, 1,0,1,0,0};  // single-beat TLP accepted
    vtab[4]  = '{0,0,0,0,1, 1,1,0,0,0};  // visible two cycles after acceptance
    vtab[5]  = '{0,0,0,0,1, 1,0,0,0,0};
    vtab[6]  = '{0,1,1,0,1, 1,0,1,0,0};  // sop, frame opens
    vtab[7]  = '{0,1,1,0,1, 1,1,1,0,1};  // second sop inside frame
    vtab[8]  = '{0,1,0,1,1, 1,1,1,0,1};  // still forwarded, flag sticky
    vtab[9]  = '{0,0,0,0,1, 1,1,0,0,1};
    vtab[10] = '{0,0,0,0,1, 1,0,0,0,1};
    vtab[11] = '{1,0,0,0,1, 0,0,0,0,0};  // only rst clears the flag
    vtab[12] = '{0,0,0,0,1, 1,0,0,0,0};
    vtab[13] = '{0,1,0,1,0, 1,0,1,0,1};  // continuation with no open frame
    vtab[14] = '{0,0,0,0,0, 1,1,0,0,1};
    vtab[15] = '{0,0,0,0,0, 1,1,0,0,1};  // held while not ready
    vtab[16] = '{0,0,0,0,1, 1,0,0,0,1};

    for (int i = 0; i < 17; i++) begin
      rst = vtab[i].rst; iv = vtab[i].iv; ordy = vtab[i].ordy;
      in_b = mk_beat(i, vtab[i].sop, vtab[i].eop, 0);
      do_cycle(last_acc);
      chk($sformatf("vec%0d_ready", i), int'(in_tlp_ready), vtab[i].e_rdy);
      chk($sformatf("vec%0d_valid", i), int'(out_tlp_valid), vtab[i].e_ov);
      chk($sformatf("vec%0d_count", i), int'(status_count), vtab[i].e_cnt);
      chk($sformatf("vec%0d_wm", i), int'(status_watermark), vtab[i].e_wm);
      chk($sformatf("vec%0d_ferr", i), int'(status_frame_err), vtab[i].e_err);
    end
    $display("table: %0d vectors applied", 17);

    // Fill with the consumer stalled: DEPTH in memory plus one in the output slot.
    reset_dut();
    ordy = 0; iv = 1; a0 = n_acc;
    for (int i = 0; i < 25; i++) begin
      in_b = mk_beat(100 + i, 1, 1, 0);
      do_cycle(last_acc);
    end
    chk("fill_accepted", n_acc - a0, DEPTH + 1);
    chk("fill_count", int'(status_count), DEPTH);
    chk("fill_ready", int'(in_tlp_ready), 0);
    chk("fill_wm", int'(status_watermark), 1);
    $display("fill: accepted=%0d count=%0d", n_acc - a0, status_count);

    // Release and stream: one beat per cycle both sides across several wraps.
    ordy = 1; seq = 1000;
    for (int i = 0; i < 110; i++) begin
      if (i == 5) begin a0 = n_acc; c0 = n_cons; end
      if (i == 105) begin
        chk("wrap_in_rate", n_acc - a0, 100);
        chk("wrap_out_rate", n_cons - c0, 100);
      end
      in_b = mk_beat(seq, 1, 1, 0);
      do_cycle(last_acc);
      if (last_acc) seq++;
    end
    iv = 0;
    for (int i = 0; i < 2*DEPTH; i++) do_cycle(last_acc);
    chk("wrap_drained", mq.size() + int'(m_ov), 0);
    $display("wrap: %0d beats streamed", seq - 1000);

    // Random valid/ready with 4-beat TLPs.
    reset_dut();
    seq = 0; budget = 0;
    in_b = mk_beat(0, 1, 0, 1);
    while (seq < 1000 && budget < 20000) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      do_cycle(last_acc);
      budget++;
      if (last_acc) begin
        seq++;
        in_b = mk_beat(seq, (seq % 4) == 0, (seq % 4) == 3, 1);
      end
    end
    chk("rand_all_sent", seq, 1000);
    iv = 0; ordy = 1; budget = 0;
    while ((mq.size() > 0 || m_ov) && budget < 100) begin
      do_cycle(last_acc);
      budget++;
    end
    chk("rand_drained", mq.size() + int'(m_ov), 0);
    chk("rand_frame_ok", int'(status_frame_err), 0);
    $display("random: %0d beats in %0d consumed total", seq, n_cons);

    // Reset with a partial packet held.
    reset_dut();
    ordy = 0; iv = 1;
    for (int i = 0; i < 5; i++) begin
      in_b = mk_beat(500 + i, i == 0, 0, 0);
      do_cycle(last_acc);
    end
    iv = 0;
    do_cycle(last_acc);
    chk("mid_count_before", int'(status_count), 4);
    rst = 1;
    do_cycle(last_acc);
    chk("mid_rst_valid", int'(out_tlp_valid), 0);
    chk("mid_rst_count", int'(status_count), 0);
    chk("mid_rst_ferr", int'(status_frame_err), 0);
    rst = 0; ordy = 1;
    do_cycle(last_acc);
    chk("mid_ready_after", int'(in_tlp_ready), 1);
    for (int i = 0; i < 4; i++) begin
      do_cycle(last_acc);
      chk("mid_no_partial", int'(out_tlp_valid), 0);
    end
    $display("mid-packet reset: done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
